point_sub: RTL

- Sequential secp256k1 affine point subtractor: computes R = A − B = A + (−B), where −B = (x_b, P − y_b).
- Inverse companion to the combinational point_add. Used to undo accumulations in the scalar-multiplication datapath and as a cross-check against point_add results.
- Iterative datapath: bit-serial modular multiplier, binary extended-Euclid inverter, single-cycle modular add/sub.
- start/done handshake; one operation in flight at a time.

---
 rtl/point_sub.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/point_sub.sv
// ============================================================================
//  Module      : point_sub
//  Description : Sequential secp256k1 affine point subtractor, R = A + (-B).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module point_sub #(
    parameter int         W = 256,
    parameter logic [W-1:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] x_a,
    input  logic [W-1:0] y_a,
    input  logic [W-1:0] x_b,
    input  logic [W-1:0] y_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] x_r,
    output logic [W-1:0] y_r,
    output logic         inf,
    output logic         dbl_req,
    output logic         err
);

    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SUB, S_INV, S_MUL_L, S_SQR, S_MUL_Y, S_DONE
    } state_t;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W]) d = d + {1'b0, P};
        return d[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_dbl(input logic [W-1:0] a);
        logic [W:0] s;
        s = {a, 1'b0};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[W-1:0];
    endfunction

    // Division by two mod an odd prime: add P first when odd so the shift is exact.
    function automatic logic [W-1:0] mod_half(input logic [W-1:0] a);
        logic [W:0] s;
        s = a[0] ? ({1'b0, a} + {1'b0, P}) : {1'b0, a};
        return s[W:1];
    endfunction

    state_t         state_q, state_d;
    logic [W-1:0]   xa_q, xa_d, ya_q, ya_d, xb_q, xb_d, yb_q, yb_d;
    logic [W-1:0]   num_q, num_d, lam_q, lam_d, acc_q, acc_d;
    logic [W-1:0]   u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
    logic [W-1:0]   xr_q, xr_d, yr_q, yr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           inf_q, inf_d, dbl_q, dbl_d, err_q, err_d;

    logic [W-1:0]   w_mul_a, w_mul_b, w_acc_step, w_ny;

    always_comb begin
        state_d = state_q;
        xa_d = xa_q;  ya_d = ya_q;  xb_d = xb_q;  yb_d = yb_q;
        num_d = num_q;  lam_d = lam_q;  acc_d = acc_q;
        u_d = u_q;  v_d = v_q;  x1_d = x1_q;  x2_d = x2_q;
        xr_d = xr_q;  yr_d = yr_q;  cnt_d = cnt_q;
        inf_d = inf_q;  dbl_d = dbl_q;  err_d = err_q;

        w_ny = (yb_q == '0) ? '0 : (P - yb_q);

        // One shared MSB-first double-and-add step; operands depend on phase.
        w_mul_a = lam_q;
        w_mul_b = lam_q;
        case (state_q)
            S_MUL_L: begin w_mul_a = num_q; w_mul_b = x1_q; end
            S_MUL_Y: begin w_mul_a = lam_q; w_mul_b = mod_sub(xa_q, xr_q); end
            default: ;
        endcase
        w_acc_step = mod_dbl(acc_q);
        if (w_mul_b[cnt_q]) w_acc_step = mod_add(w_acc_step, w_mul_a);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xa_d = x_a;  ya_d = y_a;  xb_d = x_b;  yb_d = y_b;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                xr_d = '0;  yr_d = '0;
                inf_d = 1'b0;  dbl_d = 1'b0;  err_d = 1'b0;
                if (xa_q >= P || ya_q >= P || xb_q >= P || yb_q >= P) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (xa_q == xb_q && ya_q == yb_q) begin
                    inf_d   = 1'b1;
                    state_d = S_DONE;
                end else if (xa_q == xb_q) begin
                    dbl_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                num_d   = mod_sub(ya_q, w_ny);
                u_d     = mod_sub(xa_q, xb_q);
                v_d     = P;
                x1_d    = W'(1);
                x2_d    = '0;
                state_d = S_INV;
            end
            S_INV: begin
                // Invariants: x1*den == u, x2*den == v (mod P). Each step at
                // least halves u*v, so the loop ends within 2W iterations.
                if (u_q == W'(1) || v_q == W'(1)) begin
                    x1_d    = (u_q == W'(1)) ? x1_q : x2_q;
                    acc_d   = '0;
                    cnt_d   = CW'(W - 1);
                    state_d = S_MUL_L;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = mod_half(x1_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = mod_half(x2_q);
                end else if (u_q >= v_q) begin
                    u_d  = (u_q - v_q) >> 1;
                    x1_d = mod_half(mod_sub(x1_q, x2_q));
                end else begin
                    v_d  = (v_q - u_q) >> 1;
                    x2_d = mod_half(mod_sub(x2_q, x1_q));
                end
            end
            S_MUL_L, S_SQR, S_MUL_Y: begin
                acc_d = w_acc_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    acc_d = '0;
                    cnt_d = CW'(W - 1);
                    case (state_q)
                        S_MUL_L: begin
                            lam_d   = w_acc_step;
                            state_d = S_SQR;
                        end
                        S_SQR: begin
                            xr_d    = mod_sub(mod_sub(w_acc_step, xa_q), xb_q);
                            state_d = S_MUL_Y;
                        end
                        default: begin
                            yr_d    = mod_sub(w_acc_step, ya_q);
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            xa_q <= '0;  ya_q <= '0;  xb_q <= '0;  yb_q <= '0;
            num_q <= '0;  lam_q <= '0;  acc_q <= '0;
            u_q <= '0;  v_q <= '0;  x1_q <= '0;  x2_q <= '0;
            xr_q <= '0;  yr_q <= '0;  cnt_q <= '0;
            inf_q <= 1'b0;  dbl_q <= 1'b0;  err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            xa_q <= xa_d;  ya_q <= ya_d;  xb_q <= xb_d;  yb_q <= yb_d;
            num_q <= num_d;  lam_q <= lam_d;  acc_q <= acc_d;
            u_q <= u_d;  v_q <= v_d;  x1_q <= x1_d;  x2_q <= x2_d;
            xr_q <= xr_d;  yr_q <= yr_d;  cnt_q <= cnt_d;
            inf_q <= inf_d;  dbl_q <= dbl_d;  err_q <= err_d;
        end
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);
    assign x_r     = xr_q;
    assign y_r     = yr_q;
    assign inf     = inf_q;
    assign dbl_req = dbl_q;
    assign err     = err_q;

endmodule

`default_nettype wire
